onehot_q2_sequencer: RTL and testbench
======================================

// Module: onehot_q2_sequencer
// PURPOSE
//  Registered controller around the six-state one-hot next-state datapath (states A..F, input w).
//  Holds the 6-bit one-hot state y and advances it one step per accepted valid/ready handshake.
//  Supports a direct state load and detects non-one-hot states, recovering to A after a fixed delay.
//  Drives the Moore output z and counters read by the status block.
// PARAMETERS
//  CNT_W           16  width of step_cnt and illegal_cnt (saturating)
//  RECOVER_CYCLES   2  cycles spent in RECOVER before forcing y=A (>=1)
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  reset        in   1      synchronous, active-high
//  step_valid   in   1      request to advance one transition using w
//  step_ready   out  1      high when a step can be accepted
//  w            in   1      FSM input, sampled when step_valid&step_ready
//  load_valid   in   1      overwrite state with load_state
//  load_state   in   6      raw state value; need not be one-hot
//  y            out  6      registered state; y[0]=A .. y[5]=F
//  z            out  1      Moore output, y[4]|y[5] (E or F)
//  Y1           out  1      combinational next-state bit B for current y, w
//  Y3           out  1      combinational next-state bit D for current y, w
//  illegal      out  1      high while y is not one-hot or ctrl==RECOVER
//  step_cnt     out  CNT_W  accepted steps, saturates at all-ones
//  illegal_cnt  out  CNT_W  RECOVER entries, saturates at all-ones
// BEHAVIOUR
//  Reset: y=6'b000001 (A), ctrl=RUN, counters 0. Resulting outputs: z=0, illegal=0, step_ready=1.
//  Transitions for w=1/w=0: A:B/A  B:C/D  C:E/D  D:F/A  E:E/D  F:C/D.
//  Next-state equations: Y0=(A|D)&~w, Y1=A&w, Y2=(B|F)&w, Y3=(B|C|E|F)&~w, Y4=(C|E)&w, Y5=D&w.
//  onehot_ok = popcount(y)==1. Combinational.
//  ctrl states and priorities:
//   RUN:
//    - !onehot_ok: step_ready=0. Next cycle ctrl=RECOVER, rcnt=RECOVER_CYCLES-1, illegal_cnt++.
//    - else load_valid: y<=load_state. Load has priority over a simultaneous step, which is not accepted.
//    - else step_valid: y<=next(y,w), step_cnt++. Latency is 1 cycle: y is updated on the clock edge after acceptance.
//   RECOVER:
//    - step_ready=0; load_valid is ignored.
//    - rcnt>0: rcnt--.
//    - rcnt==0: y<=A, ctrl=RUN.
//  step_ready = (ctrl==RUN) & onehot_ok & !load_valid.
//  y=0 is illegal and is recovered like any other non-one-hot value.
//  Loading an illegal value: RECOVER starts on the following cycle.
//  Reset asserted in RECOVER or mid-step wins outright and returns the reset values.
//  Y1/Y3/z are pure functions of the registered y and live w. No gating in RECOVER.
//  Counters stick at 2^CNT_W-1.
// STRUCTURE
//  Package onehot_q2_pkg:
//   - state index constants S_A=0..S_F=5
//   - ST_RESET=6'b000001
//   - ctrl enum {RUN, RECOVER}
//  Sub-module onehot_q2_next: combinational; inputs y[5:0], w; output Y[5:0]. Y1/Y3 outputs come from it.
//  Top: ctrl register, rcnt, y register, two saturating counters.
// TESTING
//  1. Reset, then steps w=1,1,0 -> y=000010, 000100, 001000; step_cnt=3; z=0 throughout.
//  2. From A, steps w=1,0,1 -> y=B, D, F, z=1 after the third step. Next step w=1 -> y=C (000100), z=0.
//  3. load_state=6'b010010 -> illegal=1, step_ready=0, illegal_cnt=1. With RECOVER_CYCLES=2, y=000001 exactly 3 cycles after the load edge.
//  4. load_valid and step_valid together with load_state=E -> y=010000, step_cnt unchanged.
//  5. Exhaustive check: all 6 legal y x w, compare Y1/Y3 against the equations, incl. Y3=1 for y=F, w=0.
//  6. Assert reset during RECOVER -> next cycle y=A, ctrl=RUN, counters 0. Force step_cnt to max, step again -> it stays at max.

Source files
------------

// File: rtl/onehot_q2_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : onehot_q2_pkg
//  Purpose : Shared constants, control-state type and helpers for the
//            six-state one-hot sequencer (states A..F).
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package onehot_q2_pkg;

  // Bit positions of each state inside the one-hot vector
  localparam int S_A = 0;
  localparam int S_B = 1;
  localparam int S_C = 2;
  localparam int S_D = 3;
  localparam int S_E = 4;
  localparam int S_F = 5;

  localparam logic [5:0] ST_RESET = 6'b000001;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } ctrl_t;

  function automatic logic is_onehot(input logic [5:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_q2_next.sv
`default_nettype none
// ============================================================================
//  Module  : onehot_q2_next
//  Purpose : Combinational one-hot next-state equations for states A..F.
//  Ports   : y [5:0] in  - current one-hot state (y[0]=A .. y[5]=F)
//            w       in  - FSM input
//            next_y  out - next-state vector
//  Revision: 1.0  initial release
// ============================================================================
module onehot_q2_next
  import onehot_q2_pkg::*;
(
  input  logic [5:0] y,
  input  logic       w,
  output logic [5:0] next_y
);

  // Each next-state bit ORs together the states that enter it on the given w.
  // Non-one-hot inputs simply produce whatever these equations give.
  always_comb begin
    next_y[S_A] = (y[S_A] | y[S_D]) & ~w;
    next_y[S_B] = y[S_A] & w;
    next_y[S_C] = (y[S_B] | y[S_F]) & w;
    next_y[S_D] = (y[S_B] | y[S_C] | y[S_E] | y[S_F]) & ~w;
    next_y[S_E] = (y[S_C] | y[S_E]) & w;
    next_y[S_F] = y[S_D] & w;
  end

endmodule
`default_nettype wire

// File: rtl/onehot_q2_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : onehot_q2_sequencer
//  Purpose : Registered controller around the one-hot next-state datapath.
//            Advances y one step per accepted handshake, supports a direct
//            state load, and recovers non-one-hot states back to A after a
//            fixed delay.
//  Ports   : clk, reset (sync, active-high)
//            step_valid/step_ready/w - step handshake and FSM input
//            load_valid/load_state   - raw state overwrite
//            y, z, Y1, Y3            - state and derived outputs
//            illegal                 - y not one-hot or recovering
//            step_cnt, illegal_cnt   - saturating event counters
//  Revision: 1.0  initial release
// ============================================================================
module onehot_q2_sequencer
  import onehot_q2_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic             w,
  input  logic             load_valid,
  input  logic [5:0]       load_state,
  output logic [5:0]       y,
  output logic             z,
  output logic             Y1,
  output logic             Y3,
  output logic             illegal,
  output logic [CNT_W-1:0] step_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  // Recovery countdown width; at least one bit even when RECOVER_CYCLES==1
  localparam int              RW        = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RW-1:0]    RCNT_INIT = RW'(RECOVER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  ctrl_t             ctrl, ctrl_nxt;
  logic [RW-1:0]     rcnt, rcnt_nxt;
  logic [5:0]        y_nxt;
  logic [5:0]        y_step;
  logic [CNT_W-1:0]  step_cnt_nxt, illegal_cnt_nxt;
  logic              onehot_ok;

  onehot_q2_next u_next (
    .y      (y),
    .w      (w),
    .next_y (y_step)
  );

  assign onehot_ok  = is_onehot(y);
  assign step_ready = (ctrl == RUN) & onehot_ok & ~load_valid;
  assign illegal    = ~onehot_ok | (ctrl == RECOVER);
  assign z          = y[S_E] | y[S_F];
  assign Y1         = y_step[S_B];
  assign Y3         = y_step[S_D];

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl        <= RUN;
      rcnt        <= '0;
      y           <= ST_RESET;
      step_cnt    <= '0;
      illegal_cnt <= '0;
    end else begin
      ctrl        <= ctrl_nxt;
      rcnt        <= rcnt_nxt;
      y           <= y_nxt;
      step_cnt    <= step_cnt_nxt;
      illegal_cnt <= illegal_cnt_nxt;
    end
  end

  always_comb begin
    ctrl_nxt        = ctrl;
    rcnt_nxt        = rcnt;
    y_nxt           = y;
    step_cnt_nxt    = step_cnt;
    illegal_cnt_nxt = illegal_cnt;
    unique case (ctrl)
      RUN: begin
        // A bad state outranks both load and step: y is held until recovery
        if (!onehot_ok) begin
          ctrl_nxt = RECOVER;
          rcnt_nxt = RCNT_INIT;
          if (illegal_cnt != CNT_MAX) illegal_cnt_nxt = illegal_cnt + 1'b1;
        end else if (load_valid) begin
          y_nxt = load_state;
        end else if (step_valid) begin
          y_nxt = y_step;
          if (step_cnt != CNT_MAX) step_cnt_nxt = step_cnt + 1'b1;
        end
      end
      RECOVER: begin
        if (rcnt != '0) begin
          rcnt_nxt = rcnt - 1'b1;
        end else begin
          y_nxt    = ST_RESET;
          ctrl_nxt = RUN;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_onehot_q2_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_onehot_q2_sequencer
//  Purpose : Self-checking bench for onehot_q2_sequencer: directed sequences,
//            a table of per-state next-state vectors, and a randomized run
//            against a transition-table reference model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_onehot_q2_sequencer;

  localparam int CW  = 4;
  localparam int RC  = 2;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          step_valid;
  logic          step_ready;
  logic          w;
  logic          load_valid;
  logic [5:0]    load_state;
  logic [5:0]    y;
  logic          z;
  logic          Y1;
  logic          Y3;
  logic          illegal;
  logic [CW-1:0] step_cnt;
  logic [CW-1:0] illegal_cnt;

  onehot_q2_sequencer #(.CNT_W(CW), .RECOVER_CYCLES(RC)) dut (
    .clk         (clk),
    .reset       (reset),
    .step_valid  (step_valid),
    .step_ready  (step_ready),
    .w           (w),
    .load_valid  (load_valid),
    .load_state  (load_state),
    .y           (y),
    .z           (z),
    .Y1          (Y1),
    .Y3          (Y3),
    .illegal     (illegal),
    .step_cnt    (step_cnt),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step_valid = 1'b0; load_valid = 1'b0; w = 1'b0; load_state = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_step(input logic wv);
    step_valid = 1'b1; w = wv;
    tick();
    step_valid = 1'b0;
  endtask

  task automatic do_load(input logic [5:0] v);
    load_valid = 1'b1; load_state = v;
    tick();
    load_valid = 1'b0;
  endtask

  // Transition table written straight from the state diagram (state index)
  int nxt_w1 [6] = '{1, 2, 4, 5, 4, 2};
  int nxt_w0 [6] = '{0, 3, 3, 0, 3, 3};

  typedef struct {
    int   idx;
    logic wv;
    logic ey1;
    logic ey3;
    logic ez;
  } vec_t;

  vec_t vecs [12];

  // Reference model state
  logic [5:0] m_y;
  bit         m_rec;
  int         m_left;
  int         m_scnt, m_icnt;

  function automatic int idx_of(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit legal(input logic [5:0] v);
    int n = 0;
    for (int i = 0; i < 6; i++) if (v[i]) n++;
    return (n == 1);
  endfunction

  task automatic model_clock();
    if (reset) begin
      m_y = 6'b000001; m_rec = 0; m_left = 0; m_scnt = 0; m_icnt = 0;
    end else if (m_rec) begin
      if (m_left > 0) m_left--;
      else begin m_y = 6'b000001; m_rec = 0; end
    end else if (!legal(m_y)) begin
      m_rec = 1; m_left = RC - 1;
      if (m_icnt < MAX) m_icnt++;
    end else if (load_valid) begin
      m_y = load_state;
    end else if (step_valid) begin
      m_y = 6'(1 << (w ? nxt_w1[idx_of(m_y)] : nxt_w0[idx_of(m_y)]));
      if (m_scnt < MAX) m_scnt++;
    end
  endtask

  task automatic model_compare();
    bit ok = legal(m_y);
    int nx;
    chk("rnd_y", 32'(y), 32'(m_y));
    chk("rnd_ready", 32'(step_ready), 32'(!m_rec && ok && !load_valid));
    chk("rnd_illegal", 32'(illegal), 32'(m_rec || !ok));
    chk("rnd_z", 32'(z), 32'(m_y[4] || m_y[5]));
    chk("rnd_step_cnt", 32'(step_cnt), 32'(m_scnt));
    chk("rnd_illegal_cnt", 32'(illegal_cnt), 32'(m_icnt));
    if (ok) begin
      nx = w ? nxt_w1[idx_of(m_y)] : nxt_w0[idx_of(m_y)];
      chk("rnd_Y1", 32'(Y1), 32'(nx == 1));
      chk("rnd_Y3", 32'(Y3), 32'(nx == 3));
    end
  endtask

  initial begin
    reset = 1'b1; step_valid = 1'b0; load_valid = 1'b0; w = 1'b0; load_state = '0;

    // Per-state next-state vectors: {state, w, Y1, Y3, z}
    vecs[0]  = '{0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{4, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{5, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{5, 1'b1, 1'b0, 1'b0, 1'b1};

    // 1: reset values and steps w=1,1,0
    do_reset();
    chk("rst_y", 32'(y), 32'h01);
    chk("rst_z", 32'(z), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_ready", 32'(step_ready), 1);
    chk("rst_step_cnt", 32'(step_cnt), 0);
    chk("rst_illegal_cnt", 32'(illegal_cnt), 0);
    do_step(1'b1); chk("t1_y0", 32'(y), 32'h02); chk("t1_z0", 32'(z), 0);
    do_step(1'b1); chk("t1_y1", 32'(y), 32'h04); chk("t1_z1", 32'(z), 0);
    do_step(1'b0); chk("t1_y2", 32'(y), 32'h08); chk("t1_z2", 32'(z), 0);
    chk("t1_step_cnt", 32'(step_cnt), 3);

    // 2: A -w1-> B -w0-> D -w1-> F, then F -w1-> C
    do_reset();
    do_step(1'b1); chk("t2_yB", 32'(y), 32'h02);
    do_step(1'b0); chk("t2_yD", 32'(y), 32'h08);
    do_step(1'b1); chk("t2_yF", 32'(y), 32'h20); chk("t2_zF", 32'(z), 1);
    do_step(1'b1); chk("t2_yC", 32'(y), 32'h04); chk("t2_zC", 32'(z), 0);

    // 3: illegal load and recovery timing
    do_reset();
    do_load(6'b010010);
    chk("t3_y_loaded", 32'(y), 32'h12);
    chk("t3_illegal", 32'(illegal), 1);
    chk("t3_ready", 32'(step_ready), 0);
    tick();
    chk("t3_illegal_cnt", 32'(illegal_cnt), 1);
    chk("t3_illegal_rec", 32'(illegal), 1);
    tick();
    chk("t3_y_hold", 32'(y), 32'h12);
    tick();
    chk("t3_y_recovered", 32'(y), 32'h01);
    chk("t3_illegal_clear", 32'(illegal), 0);
    chk("t3_ready_back", 32'(step_ready), 1);

    // 4: load wins over a simultaneous step
    do_reset();
    load_valid = 1'b1; step_valid = 1'b1; load_state = 6'b010000; w = 1'b1;
    #1 chk("t4_ready_low", 32'(step_ready), 0);
    tick();
    load_valid = 1'b0; step_valid = 1'b0;
    chk("t4_y", 32'(y), 32'h10);
    chk("t4_step_cnt", 32'(step_cnt), 0);

    // 5: table of every legal state x w
    for (int i = 0; i < 12; i++) begin
      do_reset();
      do_load(6'(1 << vecs[i].idx));
      w = vecs[i].wv;
      #1;
      chk("t5_y", 32'(y), 32'(1 << vecs[i].idx));
      chk("t5_Y1", 32'(Y1), 32'(vecs[i].ey1));
      chk("t5_Y3", 32'(Y3), 32'(vecs[i].ey3));
      chk("t5_z", 32'(z), 32'(vecs[i].ez));
    end

    // 6: reset during RECOVER, then step counter saturation
    do_reset();
    do_step(1'b1);
    do_load(6'b000000);
    tick();
    chk("t6_in_recover", 32'(illegal), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_y", 32'(y), 32'h01);
    chk("t6_illegal", 32'(illegal), 0);
    chk("t6_ready", 32'(step_ready), 1);
    chk("t6_step_cnt", 32'(step_cnt), 0);
    chk("t6_illegal_cnt", 32'(illegal_cnt), 0);
    for (int i = 0; i < MAX; i++) do_step(i[0]);
    chk("t6_cnt_max", 32'(step_cnt), MAX);
    do_step(1'b0);
    chk("t6_cnt_sat", 32'(step_cnt), MAX);

    // Randomized run against the table model
    do_reset();
    m_y = 6'b000001; m_rec = 0; m_left = 0; m_scnt = 0; m_icnt = 0;
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 49) == 0);
      load_valid = ($urandom_range(0, 5) == 0);
      load_state = ($urandom_range(0, 1) == 0) ? 6'(1 << $urandom_range(0, 5))
                                              : 6'($urandom);
      step_valid = ($urandom_range(0, 3) != 0);
      w          = 1'($urandom);
      #1;
      model_compare();
      @(posedge clk);
      model_clock();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
